// File: rtl/conf_regs_shadowed.sv
// Shadowed configuration register bank: host writes land in shadow registers,
// a write to COMMIT_ADDR copies every RW shadow slot to the active image in
// one edge, and a snapshot of the bank can be read back word by word.
module conf_regs_shadowed #(
  parameter int unsigned                    ADDR_WIDTH   = 8,
  parameter int unsigned                    DATA_WIDTH   = 8,
  parameter int unsigned                    NUM_REGS     = 16,
  parameter int unsigned                    TX_WIDTH     = 8,
  parameter logic [ADDR_WIDTH-1:0]          COMMIT_ADDR  = 8'hFF,
  parameter logic [NUM_REGS-1:0]            RO_MASK      = '0,
  parameter logic [DATA_WIDTH*NUM_REGS-1:0] RESET_VALUES = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          register_addr,
  input  logic [DATA_WIDTH-1:0]          register_data,
  input  logic                           register_rdy,
  output logic                           register_ack,
  output logic                           addr_error,
  output logic                           commit_pulse,
  output logic                           pending,
  input  logic [DATA_WIDTH*NUM_REGS-1:0] status,
  output logic [DATA_WIDTH*NUM_REGS-1:0] registers,
  input  logic                           request,
  input  logic                           req_sel,
  input  logic                           ack,
  output logic [TX_WIDTH-1:0]            tx_data,
  output logic                           empty
);

  localparam int unsigned TOTAL_W   = DATA_WIDTH * NUM_REGS;
  localparam int unsigned NUM_WORDS = TOTAL_W / TX_WIDTH;
  localparam int unsigned CNT_W     = $clog2(NUM_WORDS + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rb_state_t;

  logic [TOTAL_W-1:0] shadow_q;
  logic [TOTAL_W-1:0] shadow_d;
  logic [TOTAL_W-1:0] active_d;
  logic               accept;
  logic               rw_hit;
  logic               commit_hit;

  rb_state_t          state_q;
  rb_state_t          state_d;
  logic [TOTAL_W-1:0] shift_q;
  logic [TOTAL_W-1:0] shift_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [TOTAL_W-1:0] snapshot;

  // Address decode and next shadow/active images for an accepted transfer
  always_comb begin
    accept     = register_rdy && !register_ack;
    commit_hit = (register_addr == COMMIT_ADDR);
    rw_hit     = 1'b0;
    shadow_d   = shadow_q;
    active_d   = registers;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (!RO_MASK[i]) begin
        if (register_addr == ADDR_WIDTH'(i)) begin
          rw_hit = 1'b1;
          if (accept) shadow_d[i*DATA_WIDTH +: DATA_WIDTH] = register_data;
        end
        if (accept && commit_hit) begin
          active_d[i*DATA_WIDTH +: DATA_WIDTH] = shadow_q[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Write path: shadow/active storage, handshake pulses and pending flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q     <= RESET_VALUES;
      registers    <= RESET_VALUES;
      register_ack <= 1'b0;
      addr_error   <= 1'b0;
      commit_pulse <= 1'b0;
      pending      <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      registers    <= active_d;
      register_ack <= accept;
      addr_error   <= accept && !rw_hit && !commit_hit;
      commit_pulse <= accept && commit_hit;
      if (accept && commit_hit) begin
        pending <= 1'b0;
      end else if (accept && rw_hit) begin
        pending <= 1'b1;
      end
    end
  end

  // Readback snapshot: RO slots from live status, RW slots from active or shadow
  always_comb begin
    snapshot = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (RO_MASK[i]) begin
        snapshot[i*DATA_WIDTH +: DATA_WIDTH] = status[i*DATA_WIDTH +: DATA_WIDTH];
      end else if (req_sel) begin
        snapshot[i*DATA_WIDTH +: DATA_WIDTH] = shadow_q[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        snapshot[i*DATA_WIDTH +: DATA_WIDTH] = registers[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Readback FSM next state: load on request in IDLE, shift on ack in SHIFT
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (request) begin
          shift_d = snapshot;
          cnt_d   = CNT_W'(NUM_WORDS);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ack) begin
          if (cnt_q == CNT_W'(1)) begin
            shift_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            shift_d = shift_q >> TX_WIDTH;
            cnt_d   = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Readback FSM state register with registered empty flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      empty   <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      empty   <= (state_d == IDLE);
    end
  end

  assign tx_data = shift_q[TX_WIDTH-1:0];

endmodule

// File: tb/tb_conf_regs_shadowed.sv
// Bench for conf_regs_shadowed: 4 x 8-bit bank, register 3 read-only status.
module tb_conf_regs_shadowed;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  register_addr;
  logic [7:0]  register_data;
  logic        register_rdy;
  logic        register_ack;
  logic        addr_error;
  logic        commit_pulse;
  logic        pending;
  logic [31:0] status;
  logic [31:0] registers;
  logic        request;
  logic        req_sel;
  logic        ack;
  logic [7:0]  tx_data;
  logic        empty;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Reference model: bank contents as plain arrays
  logic [7:0] sh [3];
  logic [7:0] act[3];
  bit         pend;

  conf_regs_shadowed #(
    .ADDR_WIDTH  (8),
    .DATA_WIDTH  (8),
    .NUM_REGS    (4),
    .TX_WIDTH    (8),
    .COMMIT_ADDR (8'hFF),
    .RO_MASK     (4'b1000),
    .RESET_VALUES(32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .register_addr(register_addr),
    .register_data(register_data),
    .register_rdy (register_rdy),
    .register_ack (register_ack),
    .addr_error   (addr_error),
    .commit_pulse (commit_pulse),
    .pending      (pending),
    .status       (status),
    .registers    (registers),
    .request      (request),
    .req_sel      (req_sel),
    .ack          (ack),
    .tx_data      (tx_data),
    .empty        (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_regs();
    return {8'h00, act[2], act[1], act[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      sh[i]  = 8'h00;
      act[i] = 8'h00;
    end
    pend = 1'b0;
  endtask

  // One write transfer; checks the ack cycle and the idle cycle after it
  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    bit rw;
    bit cm;
    @(negedge clk);
    register_addr = a;
    register_data = d;
    register_rdy  = 1'b1;
    @(negedge clk);
    register_rdy = 1'b0;
    rw = (a < 8'd3);
    cm = (a == 8'hFF);
    if (rw) begin
      sh[a[1:0]] = d;
      pend = 1'b1;
    end
    if (cm) begin
      for (int i = 0; i < 3; i++) act[i] = sh[i];
      pend = 1'b0;
    end
    check("wr_ack", 32'(register_ack), 32'd1);
    check("wr_addr_error", 32'(addr_error), 32'(!(rw || cm)));
    check("wr_commit_pulse", 32'(commit_pulse), 32'(cm));
    check("wr_pending", 32'(pending), 32'(pend));
    check("wr_registers", registers, model_regs());
    @(negedge clk);
    check("wr_ack_low", 32'(register_ack), 32'd0);
    check("wr_commit_low", 32'(commit_pulse), 32'd0);
  endtask

  // Snapshot readback, consuming nacks words (4 drains the bank)
  task automatic read_words(input bit sel, input int nacks);
    logic [7:0] w[4];
    for (int i = 0; i < 3; i++) w[i] = sel ? sh[i] : act[i];
    w[3] = status[31:24];
    @(negedge clk);
    request = 1'b1;
    req_sel = sel;
    @(negedge clk);
    request = 1'b0;
    check("rb_empty_after_req", 32'(empty), 32'd0);
    check("rb_word0", 32'(tx_data), 32'(w[0]));
    for (int k = 0; k < nacks; k++) begin
      ack     = 1'b1;
      request = 1'($urandom_range(0, 1));
      @(negedge clk);
      ack     = 1'b0;
      request = 1'b0;
      if (k < 3) begin
        check("rb_empty_mid", 32'(empty), 32'd0);
        check("rb_word", 32'(tx_data), 32'(w[k+1]));
      end else begin
        check("rb_empty_end", 32'(empty), 32'd1);
        check("rb_tx_cleared", 32'(tx_data), 32'd0);
      end
    end
  endtask

  initial begin
    logic [7:0] ra;
    int         sel;
    rst           = 1'b0;
    register_addr = '0;
    register_data = '0;
    register_rdy  = 1'b0;
    status        = '0;
    request       = 1'b0;
    req_sel       = 1'b0;
    ack           = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    check("rst_registers", registers, 32'h0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_ack", 32'(register_ack), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);

    // Shadow write then commit
    do_write(8'h01, 8'h5A);
    do_write(8'hFF, 8'h00);
    check("commit_reg1", registers[15:8], 32'h5A);

    // RO and out-of-range addresses
    do_write(8'h03, 8'h77);
    do_write(8'h07, 8'h01);

    // Commit 0x11/0x22/0x33 and read back with status in slot 3
    do_write(8'h00, 8'h11);
    do_write(8'h01, 8'h22);
    do_write(8'h02, 8'h33);
    do_write(8'hFF, 8'h00);
    status = {8'hC3, 24'($urandom)};
    read_words(1'b0, 4);

    // ack while idle is ignored
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("idle_ack_empty", 32'(empty), 32'd1);
    check("idle_ack_tx", 32'(tx_data), 32'd0);

    // request and ack together in IDLE: request is served
    @(negedge clk);
    request = 1'b1;
    ack     = 1'b1;
    req_sel = 1'b0;
    @(negedge clk);
    request = 1'b0;
    ack     = 1'b0;
    check("req_ack_empty", 32'(empty), 32'd0);
    check("req_ack_word0", 32'(tx_data), 32'h11);
    repeat (4) begin
      ack = 1'b1;
      @(negedge clk);
    end
    ack = 1'b0;
    check("req_ack_drained", 32'(empty), 32'd1);

    // Shadow vs active readback
    do_write(8'h00, 8'hAB);
    read_words(1'b1, 4);
    read_words(1'b0, 4);

    // Randomized writes interleaved with readbacks
    for (int n = 0; n < 48; n++) begin
      sel = $urandom_range(0, 5);
      if (sel < 4)       ra = 8'(sel);
      else if (sel == 4) ra = 8'hFF;
      else               ra = 8'($urandom_range(4, 254));
      do_write(ra, 8'($urandom));
      if (n % 8 == 7) begin
        status = $urandom;
        read_words(1'($urandom_range(0, 1)), 4);
      end
    end

    // Reset in the middle of a readback and a write
    read_words(1'b0, 2);
    @(negedge clk);
    register_addr = 8'h00;
    register_data = 8'h99;
    register_rdy  = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("async_rst_empty", 32'(empty), 32'd1);
    check("async_rst_registers", registers, 32'h0);
    check("async_rst_pending", 32'(pending), 32'd0);
    check("async_rst_ack", 32'(register_ack), 32'd0);
    check("async_rst_tx", 32'(tx_data), 32'd0);
    register_rdy = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_no_ack", 32'(register_ack), 32'd0);
      check("post_rst_empty", 32'(empty), 32'd1);
    end
    do_write(8'h02, 8'h3C);
    do_write(8'hFF, 8'h00);
    read_words(1'b0, 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
